// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  typedef enum logic {M0, M1} master_t;
  localparam int WDOG_W = 16;
endpackage

// File: rtl/wishbone.sv
// rtl/wishbone.sv - wishbone bus bundle with master and slave views
interface wishbone #(parameter int XLEN = 32) ();
  logic              cyc;
  logic              stb;
  logic              we;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_mosi;
  logic [XLEN-1:0]   dat_miso;
  logic              ack;

  modport MASTER (output cyc, stb, we, sel, adr, dat_mosi, input dat_miso, ack);
  modport SLAVE  (input cyc, stb, we, sel, adr, dat_mosi, output dat_miso, ack);
endinterface

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - stall counter that flags the cycle in which it would reach limit
module wb_watchdog
  import wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              count_en,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);
  logic [WDOG_W-1:0] count_q, count_d;

  always_comb begin
    // Fires on the cycle whose closing edge would bring the count to limit.
    expire  = count_en && (count_q == (limit - WDOG_W'(1)));
    count_d = count_q;
    if (clear || expire) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin two-master to one-slave wishbone arbiter with watchdog
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  wishbone.SLAVE     m0,
  wishbone.SLAVE     m1,
  wishbone.MASTER    s,
  output logic [1:0] grant,
  output logic       timeout
);
  arb_state_t state_q, state_d;
  master_t    last_owner_q, last_owner_d;

  logic              owned;
  logic              own1;
  logic              own_cyc;
  logic              own_stb;
  logic              own_we;
  logic [XLEN/8-1:0] own_sel;
  logic [XLEN-1:0]   own_adr;
  logic [XLEN-1:0]   own_dat;
  logic              wd_clear;
  logic              wd_count_en;
  logic              wd_expire;

  wb_watchdog u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .limit    (WDOG_W'(TIMEOUT)),
    .expire   (wd_expire)
  );

  always_comb begin
    owned   = (state_q != IDLE);
    own1    = (state_q == OWN1);
    own_cyc = own1 ? m1.cyc      : m0.cyc;
    own_stb = own1 ? m1.stb      : m0.stb;
    own_we  = own1 ? m1.we       : m0.we;
    own_sel = own1 ? m1.sel      : m0.sel;
    own_adr = own1 ? m1.adr      : m0.adr;
    own_dat = own1 ? m1.dat_mosi : m0.dat_mosi;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = (last_owner_q == M0) ? OWN1 : OWN0;
        end else if (m0.cyc) begin
          state_d = OWN0;
        end else if (m1.cyc) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (wd_expire) begin
          state_d      = IDLE;
          last_owner_d = M0;
        end else if (!m0.cyc) begin
          last_owner_d = M0;
          state_d      = m1.cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (wd_expire) begin
          state_d      = IDLE;
          last_owner_d = M1;
        end else if (!m1.cyc) begin
          last_owner_d = M1;
          state_d      = m0.cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // s.ack only reaches the watchdog and the ack returns, never s.cyc/s.stb.
  assign wd_count_en = !rst && owned && own_cyc && own_stb && !s.ack;
  assign wd_clear    = (state_d != state_q) || s.ack;

  assign s.cyc      = !rst && owned && own_cyc;
  assign s.stb      = !rst && owned && own_cyc && own_stb;
  assign s.we       = own_we;
  assign s.sel      = own_sel;
  assign s.adr      = own_adr;
  assign s.dat_mosi = own_dat;

  assign m0.ack      = !rst && (state_q == OWN0) && s.ack && !wd_expire;
  assign m1.ack      = !rst && (state_q == OWN1) && s.ack && !wd_expire;
  assign m0.dat_miso = s.dat_miso;
  assign m1.dat_miso = s.dat_miso;

  assign grant   = rst ? 2'b00 : {state_q == OWN1, state_q == OWN0};
  assign timeout = !rst && wd_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= M0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for the two-master wishbone arbiter
module tb_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  wishbone #(.XLEN(32)) m0_if ();
  wishbone #(.XLEN(32)) m1_if ();
  wishbone #(.XLEN(32)) s_if ();

  wb_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       c0;
    logic       c1;
    logic       sack;
    logic [1:0] grant;
    logic       scyc;
    logic [31:0] sadr;
    logic       a0;
    logic       a1;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] ADR0 = 32'h0000_0100;
  localparam logic [31:0] ADR1 = 32'h0000_0200;

  task automatic add(input logic r, input logic c0, input logic c1, input logic sack,
                     input logic [1:0] g, input logic scyc, input logic a0, input logic a1,
                     input logic to);
    vec_t v;
    v.rst = r; v.c0 = c0; v.c1 = c1; v.sack = sack;
    v.grant = g; v.scyc = scyc; v.sadr = (g == 2'b10) ? ADR1 : ADR0;
    v.a0 = a0; v.a1 = a1; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, input logic c1, input logic sack);
    m0_if.cyc = c0; m0_if.stb = c0;
    m1_if.cyc = c1; m1_if.stb = c1;
    s_if.ack  = sack;
  endtask

  initial begin
    int  k;
    logic fired;
    logic seen_ack;

    m0_if.we = 1'b0; m0_if.sel = 4'hF; m0_if.adr = ADR0; m0_if.dat_mosi = 32'hAAAA_0000;
    m1_if.we = 1'b1; m1_if.sel = 4'h3; m1_if.adr = ADR1; m1_if.dat_mosi = 32'hBBBB_0000;
    s_if.dat_miso = 32'hD0D0_0000;
    drive(1'b0, 1'b0, 1'b0);

    // rst c0 c1 ack | grant scyc a0 a1 to
    add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // lone M0 request, ack two cycles after grant
    add(0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
    add(0, 1, 0, 0, 2'b01, 1, 0, 0, 0);
    add(0, 1, 0, 1, 2'b01, 1, 1, 0, 0);
    add(0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // first contention goes to M1, then direct handoff to M0
    add(0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2'b10, 1, 0, 0, 0);
    add(0, 1, 1, 1, 2'b10, 1, 0, 1, 0);
    add(0, 1, 0, 0, 2'b10, 0, 0, 0, 0);
    add(0, 1, 0, 1, 2'b01, 1, 1, 0, 0);
    add(0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // continuous contention: eight alternating single-beat transfers
    add(0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        add(0, 1, 1, 1, 2'b10, 1, 0, 1, 0);
        add(0, 1, 0, 0, 2'b10, 0, 0, 0, 0);
      end else begin
        add(0, 1, 1, 1, 2'b01, 1, 1, 0, 0);
        add(0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
      end
    end
    add(0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    // reset mid M1 transfer; last_owner returns to M0 so M1 wins next contention
    add(0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 0, 1, 0, 2'b10, 1, 0, 0, 0);
    add(1, 0, 1, 1, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 0, 2'b10, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      next_cycle();
      rst = vecs[i].rst;
      drive(vecs[i].c0, vecs[i].c1, vecs[i].sack);
      s_if.dat_miso = 32'hD0D0_0000 + i;
      @(negedge clk);
      check("grant", i, {30'd0, grant}, {30'd0, vecs[i].grant});
      check("s_cyc", i, {31'd0, s_if.cyc}, {31'd0, vecs[i].scyc});
      check("s_stb", i, {31'd0, s_if.stb}, {31'd0, vecs[i].scyc});
      check("m0_ack", i, {31'd0, m0_if.ack}, {31'd0, vecs[i].a0});
      check("m1_ack", i, {31'd0, m1_if.ack}, {31'd0, vecs[i].a1});
      check("timeout", i, {31'd0, timeout}, {31'd0, vecs[i].to});
      check("m1_dat_miso", i, m1_if.dat_miso, 32'hD0D0_0000 + i);
      if (vecs[i].scyc) begin
        check("s_adr", i, s_if.adr, vecs[i].sadr);
        check("s_we", i, {31'd0, s_if.we}, {31'd0, vecs[i].grant == 2'b10});
      end
    end

    // watchdog: M0 stalls with TIMEOUT=4, M1 joins later
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    k = 0; fired = 1'b0; seen_ack = 1'b0;
    while (!fired && k < 20) begin
      next_cycle();
      k++;
      if (k == 2) m1_if.cyc = 1'b1;
      if (k == 2) m1_if.stb = 1'b1;
      @(negedge clk);
      if (m0_if.ack) seen_ack = 1'b1;
      if (timeout) fired = 1'b1;
    end
    check("wdog_latency", 100, k, 4);
    check("wdog_m0_ack", 100, {31'd0, seen_ack}, 0);
    next_cycle();
    @(negedge clk);
    check("wdog_s_cyc", 101, {31'd0, s_if.cyc}, 0);
    check("wdog_grant", 101, {30'd0, grant}, 0);
    check("wdog_tail", 101, {31'd0, timeout}, 0);
    next_cycle();
    s_if.ack = 1'b1;
    @(negedge clk);
    check("wdog_m1_grant", 102, {30'd0, grant}, 2);
    check("wdog_m1_ack", 102, {31'd0, m1_if.ack}, 1);
    check("wdog_m0_noack", 102, {31'd0, m0_if.ack}, 0);
    next_cycle();
    s_if.ack = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    @(negedge clk);

    // ack on the cycle the count would reach TIMEOUT wins over the watchdog
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      s_if.ack = (j == 3);
      @(negedge clk);
      if (j == 0) check("race_grant", 103, {30'd0, grant}, 1);
      if (j == 3) begin
        check("race_m0_ack", 104, {31'd0, m0_if.ack}, 1);
        check("race_timeout", 104, {31'd0, timeout}, 0);
      end
    end
    next_cycle();
    s_if.ack = 1'b0;
    @(negedge clk);
    check("race_hold", 105, {30'd0, grant}, 1);
    check("race_no_to", 105, {31'd0, timeout}, 0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
